// File: rtl/exibe_sequencia_if.sv
// Bundle between the playback block, its controller and the sequence RAM.
// The slave side is the playback block; the master side is whoever drives it.
interface exibe_sequencia_if;
  logic       iniciar;
  logic [3:0] rodada;
  logic [3:0] mem_dado;
  logic [3:0] mem_endereco;
  logic [3:0] leds;
  logic       mostrando;
  logic       pronto;
  logic [3:0] db_estado;

  modport slave (
    input  iniciar, rodada, mem_dado,
    output mem_endereco, leds, mostrando, pronto, db_estado
  );

  modport master (
    output iniciar, rodada, mem_dado,
    input  mem_endereco, leds, mostrando, pronto, db_estado
  );
endinterface

// File: rtl/exibe_sequencia.sv
// Plays the stored sequence from address 0 up to the latched round on the LEDs.
// Each value is lit for TEMPO_ON cycles, then blanked for TEMPO_OFF cycles.
module exibe_sequencia #(
  parameter int TEMPO_ON  = 1000,
  parameter int TEMPO_OFF = 500,
  parameter int NT        = 12
) (
  input  logic clock,
  input  logic reset,
  exibe_sequencia_if.slave bus
);

  localparam logic [2:0] INICIAL = 3'd0;
  localparam logic [2:0] PREPARA = 3'd1;
  localparam logic [2:0] CARREGA = 3'd2;
  localparam logic [2:0] MOSTRA  = 3'd3;
  localparam logic [2:0] APAGA   = 3'd4;
  localparam logic [2:0] PROXIMO = 3'd5;
  localparam logic [2:0] FIM     = 3'd6;

  localparam logic [NT-1:0] FIM_ON  = NT'(TEMPO_ON - 1);
  localparam logic [NT-1:0] FIM_OFF = NT'(TEMPO_OFF - 1);

  logic [2:0]    estado;
  logic [3:0]    endereco;
  logic [3:0]    rodada_reg;
  logic [3:0]    leds_reg;
  logic [NT-1:0] timer;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado     <= INICIAL;
      endereco   <= 4'd0;
      rodada_reg <= 4'd0;
      leds_reg   <= 4'd0;
      timer      <= '0;
    end else begin
      case (estado)
        INICIAL: begin
          if (bus.iniciar) begin
            rodada_reg <= bus.rodada;
            endereco   <= 4'd0;
            estado     <= PREPARA;
          end
        end
        PREPARA: estado <= CARREGA;
        // The RAM output is valid here because it registered the address last cycle.
        CARREGA: begin
          leds_reg <= bus.mem_dado;
          timer    <= '0;
          estado   <= MOSTRA;
        end
        MOSTRA: begin
          if (timer == FIM_ON) begin
            timer    <= '0;
            leds_reg <= 4'd0;
            estado   <= APAGA;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        APAGA: begin
          if (timer == FIM_OFF) begin
            timer  <= '0;
            estado <= PROXIMO;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        // Compare before incrementing so round 15 never wraps the address to 0.
        PROXIMO: begin
          if (endereco == rodada_reg) begin
            estado <= FIM;
          end else begin
            endereco <= endereco + 4'd1;
            estado   <= PREPARA;
          end
        end
        FIM: begin
          leds_reg <= 4'd0;
          estado   <= INICIAL;
        end
        default: begin
          leds_reg <= 4'd0;
          estado   <= INICIAL;
        end
      endcase
    end
  end

  assign bus.mem_endereco = endereco;
  assign bus.leds         = leds_reg;
  assign bus.pronto       = (estado == FIM);
  assign bus.mostrando    = (estado != INICIAL) && (estado != FIM);
  assign bus.db_estado    = {1'b0, estado};

endmodule

// File: tb/tb_exibe_sequencia.sv
// Bench for exibe_sequencia with short display times and a preloaded RAM model.
module tb_exibe_sequencia;
  localparam int TON  = 4;
  localparam int TOFF = 2;
  localparam int PER  = TON + TOFF + 3;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  exibe_sequencia_if bus();

  exibe_sequencia #(.TEMPO_ON(TON), .TEMPO_OFF(TOFF), .NT(3)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Synchronous RAM model: address i holds i+1, one-cycle read latency.
  logic [3:0] ram [16];
  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 4'(i + 1);
    bus.mem_dado = 4'd0;
  end
  always @(posedge clock) bus.mem_dado <= ram[bus.mem_endereco];

  typedef struct {
    logic [3:0] rodada;
    bit         pulse_mid;
    bit         keep_high;
    int         pronto_cycle;
  } vec_t;

  vec_t vecs [6];
  logic [3:0] sb_q [$];
  logic [3:0] prev_est = 4'd0;

  // Scoreboard: each entry into the show state must display the next queued value.
  always @(negedge clock) begin
    if (bus.db_estado == 4'd3 && prev_est != 4'd3) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected leds=%0d with empty queue, required no display", bus.leds);
      end else begin
        logic [3:0] want;
        want = sb_q.pop_front();
        if (bus.leds !== want) begin
          bad++;
          $display("FAIL sb_leds got=%0d required=%0d", bus.leds, want);
        end
      end
    end
    prev_est = bus.db_estado;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Cycle k counts from the edge that sampled iniciar; r is the latched round.
  task automatic check_output(input int k, input int r, input string tag);
    logic [13:0] act, exp;
    int n, v, o;
    logic [3:0] e_leds, e_addr, e_est;
    logic e_most, e_pronto;
    n = (r + 1) * PER;
    e_leds = 4'd0; e_addr = 4'(r); e_est = 4'd0; e_most = 1'b0; e_pronto = 1'b0;
    if (k >= 1 && k <= n) begin
      v = (k - 1) / PER;
      o = (k - 1) % PER;
      e_addr = 4'(v);
      e_most = 1'b1;
      if (o == 0)           e_est = 4'd1;
      else if (o == 1)      e_est = 4'd2;
      else if (o < 2 + TON) begin e_est = 4'd3; e_leds = 4'(v + 1); end
      else if (o < PER - 1) e_est = 4'd4;
      else                  e_est = 4'd5;
    end else if (k == n + 1) begin
      e_est = 4'd6;
      e_pronto = 1'b1;
    end
    exp = {e_leds, e_addr, e_most, e_pronto, e_est};
    act = {bus.leds, bus.mem_endereco, bus.mostrando, bus.pronto, bus.db_estado};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got leds=%0d addr=%0d most=%b pronto=%b est=%0d required leds=%0d addr=%0d most=%b pronto=%b est=%0d",
               tag, k, act[13:10], act[9:6], act[5], act[4], act[3:0],
               exp[13:10], exp[9:6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  task automatic apply_vector(input vec_t t, input int idx);
    int r, n, pronto_count, pronto_at;
    string tag;
    tag = $sformatf("vec%0d", idx);
    r = int'(t.rodada);
    n = (r + 1) * PER;
    pronto_count = 0;
    pronto_at = -1;
    bus.rodada  = t.rodada;
    bus.iniciar = 1'b1;
    for (int v = 0; v <= r; v++) sb_q.push_back(4'(v + 1));
    step();
    if (!t.keep_high) bus.iniciar = 1'b0;
    for (int k = 1; k <= n + 2; k++) begin
      check_output(k, r, tag);
      if (bus.pronto === 1'b1) begin
        pronto_count++;
        pronto_at = k;
      end
      if (t.pulse_mid && k == TON + 3) bus.iniciar = 1'b1;
      if (t.pulse_mid && k == TON + 4) bus.iniciar = 1'b0;
      if (t.pulse_mid && k == PER + 3) bus.rodada = 4'd5;
      if (k < n + 2) step();
    end
    total++;
    if (pronto_count != 1 || pronto_at != t.pronto_cycle) begin
      bad++;
      $display("FAIL %s_pronto count=%0d at=%0d required count=1 at=%0d",
               tag, pronto_count, pronto_at, t.pronto_cycle);
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain pending=%0d required=0", tag, sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    vecs[0] = '{rodada: 4'd2,  pulse_mid: 1'b0, keep_high: 1'b0, pronto_cycle: 28};
    vecs[1] = '{rodada: 4'd0,  pulse_mid: 1'b0, keep_high: 1'b0, pronto_cycle: 10};
    vecs[2] = '{rodada: 4'd15, pulse_mid: 1'b0, keep_high: 1'b0, pronto_cycle: 145};
    vecs[3] = '{rodada: 4'd2,  pulse_mid: 1'b1, keep_high: 1'b0, pronto_cycle: 28};
    vecs[4] = '{rodada: 4'd1,  pulse_mid: 1'b0, keep_high: 1'b1, pronto_cycle: 19};
    vecs[5] = '{rodada: 4'd1,  pulse_mid: 1'b0, keep_high: 1'b0, pronto_cycle: 19};

    reset = 1'b1;
    bus.iniciar = 1'b0;
    bus.rodada  = 4'd0;
    repeat (3) step();
    check_output(0, 0, "reset");
    reset = 1'b0;
    step();
    check_output(0, 0, "idle");

    for (int i = 0; i < 6; i++) apply_vector(vecs[i], i);

    // Reset during the second value's show window must abort without pronto.
    bus.rodada  = 4'd2;
    bus.iniciar = 1'b1;
    for (int v = 0; v < 3; v++) sb_q.push_back(4'(v + 1));
    step();
    bus.iniciar = 1'b0;
    for (int k = 1; k <= PER + 3; k++) begin
      check_output(k, 2, "pre_reset");
      if (k < PER + 3) step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_output(0, 0, "mid_reset");
    sb_q.delete();
    for (int k = 0; k < 5; k++) begin
      step();
      check_output(0, 0, "post_reset");
    end

    apply_vector(vecs[1], 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
